// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the execute stage, the result queue and writeback.
// The master side produces results and consumes the queue head; the slave side is the queue.
interface alu_result_queue_if #(
  parameter int DATA_WDTH = 32
);
  logic                 in_valid;
  logic [DATA_WDTH-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [DATA_WDTH-1:0] out_data;
  logic                 out_zero;
  logic                 out_neg;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg
  );
endinterface

// File: rtl/alu_result_queue.sv
// Result-capture FIFO behind the ALU shifter: buffers results with zero/negative tags,
// drops and counts results that arrive while full, and presents a fully registered head.
module alu_result_queue #(
  parameter int DATA_WDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_queue_if.slave        bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     drop_clr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic is_zero(input logic [DATA_WDTH-1:0] d);
    return (d == {DATA_WDTH{1'b0}});
  endfunction

  function automatic logic is_neg(input logic [DATA_WDTH-1:0] d);
    return d[DATA_WDTH-1];
  endfunction

  logic [DATA_WDTH-1:0] mem_r [DEPTH];
  logic                 zero_r [DEPTH];
  logic                 neg_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic [CNT_W-1:0]     drop_cnt_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [DATA_WDTH-1:0] out_data_r;
  logic                 out_zero_r;
  logic                 out_neg_r;

  logic                 full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 drop_s;
  logic [PTR_W-1:0]     rd_nxt_s;
  logic [LVL_W-1:0]     level_nxt_s;
  logic [DATA_WDTH-1:0] head_data_s;
  logic                 head_zero_s;
  logic                 head_neg_s;

  // Push/pop/drop qualification and next-state level
  always_comb begin
    full_s   = (level_r == FULL_LVL);
    push_s   = bus.in_valid & ~full_s & ~flush;
    pop_s    = out_valid_r & bus.out_ready & ~flush;
    drop_s   = bus.in_valid & full_s & ~flush;
    rd_nxt_s = rd_ptr_r + PTR_W'(1);
    if (flush) begin
      level_nxt_s = {LVL_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level_r + LVL_W'(1);
        2'b01:   level_nxt_s = level_r - LVL_W'(1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Next head contents; the head register holds its old value whenever the queue drains
  always_comb begin
    head_data_s = out_data_r;
    head_zero_s = out_zero_r;
    head_neg_s  = out_neg_r;
    if (flush) begin
      head_data_s = out_data_r;
    end else if (pop_s && (level_r > LVL_W'(1))) begin
      head_data_s = mem_r[rd_nxt_s];
      head_zero_s = zero_r[rd_nxt_s];
      head_neg_s  = neg_r[rd_nxt_s];
    end else if (push_s && ((level_r == LVL_W'(0)) || (pop_s && (level_r == LVL_W'(1))))) begin
      head_data_s = bus.in_data;
      head_zero_s = is_zero(bus.in_data);
      head_neg_s  = is_neg(bus.in_data);
    end else begin
      head_data_s = out_data_r;
    end
  end

  // Storage, pointers, level and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i]  <= {DATA_WDTH{1'b0}};
        zero_r[i] <= 1'b0;
        neg_r[i]  <= 1'b0;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WDTH{1'b0}};
      out_zero_r  <= 1'b0;
      out_neg_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r]  <= bus.in_data;
        zero_r[wr_ptr_r] <= is_zero(bus.in_data);
        neg_r[wr_ptr_r]  <= is_neg(bus.in_data);
      end
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_nxt_s;
      end
      level_r     <= level_nxt_s;
      in_ready_r  <= (level_nxt_s != FULL_LVL);
      out_valid_r <= (level_nxt_s != LVL_W'(0));
      out_data_r  <= head_data_s;
      out_zero_r  <= head_zero_s;
      out_neg_r   <= head_neg_s;
    end
  end

  // Saturating overflow counter; an explicit clear beats a same-cycle drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_clr) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != CNT_MAX)) begin
      drop_cnt_r <= drop_cnt_r + CNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_zero  = out_zero_r;
  assign bus.out_neg   = out_neg_r;
  assign level         = level_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: hand-computed vectors for ordering, overflow,
// saturation, flush and asynchronous reset.
module tb_alu_result_queue;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       drop_clr;
  logic [2:0] level;
  logic [7:0] drop_cnt;
  int         checks_r;
  int         errors_r;
  logic [31:0] exp_q [$];
  logic [31:0] e2 [4];
  logic [31:0] e_s;

  alu_result_queue_if #(.DATA_WDTH(32)) bus ();

  alu_result_queue #(.DATA_WDTH(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .level(level), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    rst_n = 1'b0; flush = 1'b0; drop_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'h0, bus.in_ready},  64'h1);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_out_data",  {32'h0, bus.out_data},  64'h0);
    check("rst_out_zero",  {63'h0, bus.out_zero},  64'h0);
    check("rst_out_neg",   {63'h0, bus.out_neg},   64'h0);
    check("rst_level",     {61'h0, level},         64'h0);
    check("rst_drop",      {56'h0, drop_cnt},      64'h0);
    rst_n = 1'b1;
    tick();

    // 1: single zero result, one-cycle latency
    push_one(32'h0000_0000);
    check("t1_valid", {63'h0, bus.out_valid}, 64'h1);
    check("t1_data",  {32'h0, bus.out_data},  64'h0);
    check("t1_zero",  {63'h0, bus.out_zero},  64'h1);
    check("t1_neg",   {63'h0, bus.out_neg},   64'h0);
    check("t1_level", {61'h0, level},         64'h1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t1_empty", {63'h0, bus.out_valid}, 64'h0);

    // 2: fill, overflow drop, ordered drain
    e2[0] = 32'h8000_0001; e2[1] = 32'h1; e2[2] = 32'h2; e2[3] = 32'h3;
    for (int i = 0; i < 4; i++) push_one(e2[i]);
    check("t2_level",    {61'h0, level},        64'h4);
    check("t2_in_ready", {63'h0, bus.in_ready}, 64'h0);
    push_one(32'h0000_00FF);
    check("t2_drop",     {56'h0, drop_cnt},     64'h1);
    check("t2_level_ff", {61'h0, level},        64'h4);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", {32'h0, bus.out_data}, {32'h0, e2[i]});
      check("t2_neg",  {63'h0, bus.out_neg},  {63'h0, e2[i][31]});
      check("t2_zero", {63'h0, bus.out_zero}, 64'h0);
      bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
    check("t2_drained", {61'h0, level}, 64'h0);

    // 4: saturation, clear-wins, and full drops even with out_ready
    for (int i = 0; i < 4; i++) push_one(32'h10 + 32'(i));
    bus.in_valid = 1'b1; bus.in_data = 32'hBAD;
    repeat (300) tick();
    check("t4_sat", {56'h0, drop_cnt}, 64'hFF);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check("t4_clr", {56'h0, drop_cnt}, 64'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t4_full_pop_drop", {56'h0, drop_cnt}, 64'h1);
    check("t4_full_pop_lvl",  {61'h0, level},    64'h3);
    check("t4_head",          {32'h0, bus.out_data}, 64'h11);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    check("t4_drained", {61'h0, level}, 64'h0);

    // 3: level 2 with continuous push+pop across pointer wrap
    exp_q.delete();
    push_one(32'h100); exp_q.push_back(32'h100);
    push_one(32'h101); exp_q.push_back(32'h101);
    check("t3_level0", {61'h0, level}, 64'h2);
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'(i); bus.out_ready = 1'b1;
      e_s = exp_q.pop_front();
      check("t3_data", {32'h0, bus.out_data}, {32'h0, e_s});
      exp_q.push_back(32'(i));
      tick();
      check("t3_level", {61'h0, level}, 64'h2);
    end
    bus.in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e_s = exp_q.pop_front();
      check("t3_tail", {32'h0, bus.out_data}, {32'h0, e_s});
      tick();
    end
    bus.out_ready = 1'b0;
    check("t3_drained", {61'h0, level}, 64'h0);

    // 5: flush overrides push and pop; drop_cnt untouched
    push_one(32'hA); push_one(32'hB); push_one(32'hC);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD; bus.out_ready = 1'b1;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("t5_level",    {61'h0, level},         64'h0);
    check("t5_valid",    {63'h0, bus.out_valid}, 64'h0);
    check("t5_drop",     {56'h0, drop_cnt},      64'h1);
    check("t5_in_ready", {63'h0, bus.in_ready},  64'h1);
    push_one(32'h55);
    check("t5_alone_lvl",  {61'h0, level},        64'h1);
    check("t5_alone_data", {32'h0, bus.out_data}, 64'h55);
    push_one(32'h56); push_one(32'h57); push_one(32'h58);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hBEEF;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("t5_full_flush_drop", {56'h0, drop_cnt}, 64'h1);
    check("t5_full_flush_lvl",  {61'h0, level},    64'h0);

    // 6: asynchronous reset between edges
    push_one(32'h7); push_one(32'h8); push_one(32'h9);
    check("t6_pre_level", {61'h0, level}, 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {63'h0, bus.out_valid}, 64'h0);
    check("t6_level", {61'h0, level},         64'h0);
    check("t6_drop",  {56'h0, drop_cnt},      64'h0);
    check("t6_data",  {32'h0, bus.out_data},  64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end
endmodule
